apb_master_bridge: RTL and testbench

Single-outstanding APB3 requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns a valid/ready response. It sits directly upstream of the APB register-file slave, drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA, and consumes its PRDATA/PREADY/PSLVERR.

---
 rtl/apb_master_bridge.sv | 150 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Single-outstanding APB3 requester: a valid/ready command becomes one
// SETUP/ACCESS transfer, and its outcome returns as a valid/ready response.
// Optional ACCESS watchdog: define APB_MASTER_TIMEOUT_EN to compile it in.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB requester side
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [1:0] state;
  logic       rst_done;   // keeps cmd_ready low while PRESETn is asserted
  logic       cmd_fire;
  logic       access_done;

  // Control outputs are pure state decodes so reset drops them asynchronously
  assign cmd_ready = (state == IDLE) && rst_done;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Expiry is decided on the edge that would bring the count to the limit,
  // so the bus spends exactly TIMEOUT_CYCLES cycles in ACCESS.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_expire;
  logic             rsp_timeout_q;

  assign tmo_expire  = (state == ACCESS) && !PREADY && (tmo_cnt == TMO_LAST);
  assign rsp_timeout = rsp_timeout_q;

  // Watchdog: cleared in SETUP, counts ACCESS cycles that lack PREADY
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Timeout flag travels with the response; PREADY on the expiry edge wins
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_timeout_q <= 1'b0;
    end else if (state == ACCESS && PREADY) begin
      rsp_timeout_q <= 1'b0;
    end else if (tmo_expire) begin
      rsp_timeout_q <= 1'b1;
    end
  end
`else
  logic tmo_expire;

  assign tmo_expire  = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign access_done = (state == ACCESS) && (PREADY || tmo_expire);

  // Reset-release tracker for cmd_ready
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  // Transfer sequencer: IDLE -> SETUP -> ACCESS (waits on PREADY) -> RESP
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (cmd_fire) state <= SETUP;
        SETUP:   state <= ACCESS;
        ACCESS:  if (access_done) state <= RESP;
        RESP:    if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // APB address/data latched at accept and held until the next command
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (cmd_fire) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

  // Response capture at ACCESS completion; timeout forces error with zero data
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (state == ACCESS && PREADY) begin
      rsp_err   <= PSLVERR;
      rsp_rdata <= PWRITE ? '0 : PRDATA;
    end else if (tmo_expire) begin
      rsp_err   <= 1'b1;
      rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed vector table driven through the bridge, with the bench acting as
// a register-file APB slave (0x1000..0x10FC valid, elsewhere PSLVERR).
// Hand sequences cover response back-pressure, reset mid-ACCESS and, when
// APB_MASTER_TIMEOUT_EN is defined, the ACCESS watchdog.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [64];

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned waits;
    int unsigned hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a >= 32'h1000) && (a <= 32'h10FC);
  endfunction

  // Runs one command through the bridge; starts and ends on a falling edge.
  task automatic xfer(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, " cmd_ready idle"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'h0BAD_F00D;
    // SETUP: junk slave response must be ignored here
    chk({tag, " setup PSEL"}, {31'd0, PSEL}, 32'd1);
    chk({tag, " setup PENABLE"}, {31'd0, PENABLE}, 32'd0);
    chk({tag, " setup cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hCAFE_0001;
    @(posedge PCLK);
    @(negedge PCLK);
    for (int unsigned w = 0; w <= v.waits; w++) begin
      chk({tag, " access PSEL"}, {31'd0, PSEL}, 32'd1);
      chk({tag, " access PENABLE"}, {31'd0, PENABLE}, 32'd1);
      chk({tag, " access PADDR"}, PADDR, v.addr);
      chk({tag, " access PWRITE"}, {31'd0, PWRITE}, {31'd0, v.wr});
      if (v.wr) chk({tag, " access PWDATA"}, PWDATA, v.wdata);
      chk({tag, " access rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      if (w == v.waits) begin
        PREADY  = 1'b1;
        PSLVERR = !in_range(v.addr);
        if (v.wr) begin
          PRDATA = 32'hA5A5_A5A5;
          if (in_range(v.addr)) mem[v.addr[7:2]] = v.wdata;
        end else begin
          PRDATA = in_range(v.addr) ? mem[v.addr[7:2]] : 32'h0;
        end
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hCAFE_0002;
      end
      @(posedge PCLK);
      @(negedge PCLK);
    end
    // RESP: slave inputs toggled to prove they are ignored
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hCAFE_0003;
    for (int unsigned h = 0; h <= v.hold; h++) begin
      chk({tag, " resp rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, " resp rsp_rdata"}, rsp_rdata, v.exp_rdata);
      chk({tag, " resp rsp_err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
      chk({tag, " resp rsp_timeout"}, {31'd0, rsp_timeout}, 32'd0);
      chk({tag, " resp PSEL"}, {31'd0, PSEL}, 32'd0);
      chk({tag, " resp PENABLE"}, {31'd0, PENABLE}, 32'd0);
      chk({tag, " resp cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
      chk({tag, " resp PADDR hold"}, PADDR, v.addr);
      rsp_ready = (h == v.hold);
      @(posedge PCLK);
      @(negedge PCLK);
    end
    rsp_ready = 1'b0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    chk({tag, " after rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    vec_t rv;
    int cyc;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    //            wr    addr          wdata         waits hold exp_rdata     err
    vecs[0]  = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_1000, 32'h0,         0, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_2000, 32'h0,         1, 0, 32'h0000_0000, 1'b1};
    vecs[3]  = '{1'b1, 32'h0000_2000, 32'h1234_5678, 0, 0, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 32'h0000_1004, 32'h1111_1111, 0, 0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_1008, 32'h2222_2222, 1, 0, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_1004, 32'h3333_3333, 2, 0, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_1008, 32'h4444_4444, 3, 0, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_1004, 32'h5555_5555, 4, 0, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_1008, 32'h6666_6666, 5, 0, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_1004, 32'h0,         0, 3, 32'h5555_5555, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_1008, 32'h0,         2, 0, 32'h6666_6666, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_1000, 32'h0,         1, 1, 32'hDEAD_BEEF, 1'b0};

    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    // Reset state
    #1;
    chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("reset PSEL", {31'd0, PSEL}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset PADDR", PADDR, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("post-reset cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 13; i++) xfer(vecs[i], i);

    // Reset pulsed mid-ACCESS: bus drops at once, nothing is delivered later
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1010; cmd_wdata = 32'h7777_7777;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("pre-reset PENABLE", {31'd0, PENABLE}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async reset PSEL", {31'd0, PSEL}, 32'd0);
    chk("async reset PENABLE", {31'd0, PENABLE}, 32'd0);
    chk("async reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("release cmd_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("no stale rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("no stale PSEL", {31'd0, PSEL}, 32'd0);
      @(posedge PCLK);
      @(negedge PCLK);
    end
    PREADY = 1'b0;
    // Discarded write never reached the slave: 0x1010 still reads zero
    rv = '{1'b0, 32'h0000_1010, 32'h0, 0, 0, 32'h0000_0000, 1'b0};
    xfer(rv, 20);

`ifdef APB_MASTER_TIMEOUT_EN
    // Watchdog: slave never answers
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1000; cmd_wdata = '0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PREADY = 1'b0; PRDATA = 32'hCAFE_0004;
    @(posedge PCLK);
    @(negedge PCLK);
    cyc = 0;
    while (PENABLE && cyc < 200) begin
      cyc++;
      @(posedge PCLK);
      @(negedge PCLK);
    end
    chk("timeout access cycles", cyc, TMO);
    chk("timeout rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("timeout rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("timeout rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    chk("timeout rsp_rdata", rsp_rdata, 32'd0);
    chk("timeout PSEL", {31'd0, PSEL}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("timeout handshake cmd_ready", {31'd0, cmd_ready}, 32'd1);
    // A normal transfer afterwards clears the timeout flag
    xfer(vecs[1], 30);
`else
    cyc = 0;
    chk("no-watchdog rsp_timeout", {31'd0, rsp_timeout}, {31'd0, 1'b0} + cyc);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so a stuck DUT still produces a summary line
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
